bru_redirect: RTL and testbench

BRU_REDIRECT -- requirements
Module: bru_redirect

---
 rtl/bru_redirect_pkg.sv | 12 +
 rtl/bru_redirect_perf_cnt32.sv | 24 ++
 rtl/bru_redirect.sv | 102 ++++++++++
 tb/tb_bru_redirect.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bru_redirect_pkg.sv
// Shared definitions for the branch-resolution redirect block: address width
// default and the redirect FSM state encoding.
package bru_redirect_pkg;

  localparam int GRLEN_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_e;

endpackage

// File: rtl/bru_redirect_perf_cnt32.sv
// Free-running 32-bit event counter; wraps from all-ones to zero.
module perf_cnt32 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc,
  output logic [31:0] value
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = inc ? cnt_q + 32'd1 : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/bru_redirect.sv
// Turns resolved branches into predictor updates, perf counts and, on a
// mispredict, a held fetch redirect plus a one-cycle younger-instruction squash.
module bru_redirect
  import bru_redirect_pkg::*;
#(
  parameter int GRLEN = GRLEN_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             bru_valid,
  input  logic             bru_cancel,
  input  logic             bru_taken,
  input  logic [GRLEN-1:0] bru_pc,
  input  logic [GRLEN-1:0] bru_target,
  input  logic             exc_flush,
  output logic             redirect_valid,
  output logic [GRLEN-1:0] redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_younger,
  output logic             upd_valid,
  output logic [GRLEN-1:0] upd_pc,
  output logic             upd_taken,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mis_cnt
);

  state_e           state_q, state_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [GRLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic             flush_younger_q, flush_younger_d;
  logic             upd_valid_q, upd_valid_d;
  logic [GRLEN-1:0] upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;

  logic accept;
  logic mispredict;
  logic handshake;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    // Branches seen while a redirect is outstanding are on the wrong path.
    accept     = (state_q == IDLE) && bru_valid && !exc_flush;
    mispredict = accept && bru_cancel;
    handshake  = redirect_valid_q && redirect_ready;

    state_d = state_q;
    if (exc_flush)       state_d = IDLE;
    else if (mispredict) state_d = REDIR;
    else if (handshake)  state_d = IDLE;

    redirect_valid_d = (state_d == REDIR);
    redirect_pc_d    = mispredict ? bru_target : redirect_pc_q;
    flush_younger_d  = mispredict;

    upd_valid_d = accept;
    upd_pc_d    = accept ? bru_pc    : upd_pc_q;
    upd_taken_d = accept ? bru_taken : upd_taken_q;
  end

  // NOTE: all flops here, data included, take the async reset so nothing stale survives reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_younger_q  <= 1'b0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_younger_q  <= flush_younger_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
    end
  end

  perf_cnt32 u_br_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (accept),
    .value  (br_cnt)
  );

  perf_cnt32 u_mis_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (mispredict),
    .value  (mis_cnt)
  );

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_younger  = flush_younger_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;

endmodule

// File: tb/tb_bru_redirect.sv
// Directed scenarios followed by random traffic, compared each cycle against a
// rule-level reference model of the redirect block.
module tb_bru_redirect;
  import bru_redirect_pkg::*;

  localparam int W = GRLEN_DEFAULT;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         bru_valid = 1'b0, bru_cancel = 1'b0, bru_taken = 1'b0;
  logic [W-1:0] bru_pc = '0, bru_target = '0;
  logic         exc_flush = 1'b0, redirect_ready = 1'b0;
  logic         redirect_valid, flush_younger, upd_valid, upd_taken;
  logic [W-1:0] redirect_pc, upd_pc;
  logic [31:0]  br_cnt, mis_cnt;

  bru_redirect #(.GRLEN(W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bru_valid      (bru_valid),
    .bru_cancel     (bru_cancel),
    .bru_taken      (bru_taken),
    .bru_pc         (bru_pc),
    .bru_target     (bru_target),
    .exc_flush      (exc_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_younger  (flush_younger),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .br_cnt         (br_cnt),
    .mis_cnt        (mis_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a pending redirect (or not), plus the last reported outputs.
  bit           m_pending;
  logic [W-1:0] m_rpc, m_upd_pc;
  bit           m_upd_valid, m_upd_taken, m_flush;
  int unsigned  m_br, m_mis;

  task automatic model_reset();
    m_pending = 0; m_rpc = '0; m_upd_pc = '0;
    m_upd_valid = 0; m_upd_taken = 0; m_flush = 0;
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_step();
    m_upd_valid = 0;
    m_flush     = 0;
    if (exc_flush) begin
      m_pending = 0;
    end else if (m_pending) begin
      if (redirect_ready) m_pending = 0;
    end else if (bru_valid) begin
      m_upd_valid = 1; m_upd_pc = bru_pc; m_upd_taken = bru_taken;
      m_br = m_br + 1;
      if (bru_cancel) begin
        m_mis = m_mis + 1; m_flush = 1; m_pending = 1; m_rpc = bru_target;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":redirect_valid"}, 64'(redirect_valid), 64'(m_pending));
    check({tag, ":redirect_pc"},    64'(redirect_pc),    64'(m_rpc));
    check({tag, ":flush_younger"},  64'(flush_younger),  64'(m_flush));
    check({tag, ":upd_valid"},      64'(upd_valid),      64'(m_upd_valid));
    check({tag, ":upd_pc"},         64'(upd_pc),         64'(m_upd_pc));
    check({tag, ":upd_taken"},      64'(upd_taken),      64'(m_upd_taken));
    check({tag, ":br_cnt"},         64'(br_cnt),         64'(m_br));
    check({tag, ":mis_cnt"},        64'(mis_cnt),        64'(m_mis));
  endtask

  task automatic drive(input bit v, input bit c, input bit t, input logic [W-1:0] pc,
                       input logic [W-1:0] tgt, input bit exc, input bit rdy);
    bru_valid = v; bru_cancel = c; bru_taken = t; bru_pc = pc;
    bru_target = tgt; exc_flush = exc; redirect_ready = rdy;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  int rv_cycles;
  int flush_cycles;

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Correct prediction, accepted on the first edge after release.
    drive(1, 0, 1, 32'h1c00_0100, 32'h1c00_0180, 0, 0);
    cycle("correct");
    check("correct:upd_valid_lit", 64'(upd_valid), 64'd1);
    check("correct:br_cnt_lit", 64'(br_cnt), 64'd1);

    // Mispredict held off by fetch for three cycles.
    rv_cycles = 0; flush_cycles = 0;
    drive(1, 1, 0, 32'h1c00_0104, 32'h1c00_0200, 0, 0);
    cycle("mispred");
    rv_cycles += int'(redirect_valid); flush_cycles += int'(flush_younger);
    drive(0, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle("mispred_wait");
      rv_cycles += int'(redirect_valid); flush_cycles += int'(flush_younger);
    end
    // Wrong-path branches while the redirect is still outstanding.
    drive(1, 1, 1, 32'h1c00_0300, 32'h1c00_0400, 0, 0);
    cycle("wrongpath");
    rv_cycles += int'(redirect_valid); flush_cycles += int'(flush_younger);
    // Handshake cycle also carries a wrong-path branch.
    drive(1, 1, 1, 32'h1c00_0304, 32'h1c00_0500, 0, 1);
    cycle("handshake");
    rv_cycles += int'(redirect_valid); flush_cycles += int'(flush_younger);
    check("mispred:redirect_cycles", 64'(rv_cycles), 64'd4);
    check("mispred:flush_cycles", 64'(flush_cycles), 64'd1);
    check("mispred:pc_lit", 64'(redirect_pc), 64'h1c00_0200);

    // Ready with nothing pending is ignored.
    drive(0, 0, 0, '0, '0, 0, 1);
    cycle("ready_idle");

    // Exception in the same cycle as a mispredict drops the branch.
    drive(1, 1, 1, 32'h1c00_0600, 32'h1c00_0700, 1, 0);
    cycle("exc_same");

    // Exception while a redirect is pending, then exception on a handshake.
    drive(1, 1, 0, 32'h1c00_0800, 32'h1c00_0900, 0, 0);
    cycle("exc_mid_enter");
    drive(0, 0, 0, '0, '0, 1, 0);
    cycle("exc_mid");
    drive(1, 1, 0, 32'h1c00_0a00, 32'h1c00_0b00, 0, 0);
    cycle("exc_hs_enter");
    drive(0, 0, 0, '0, '0, 1, 1);
    cycle("exc_hs");

    // Counter wrap: preload the mispredict counter to all-ones.
    drive(0, 0, 0, '0, '0, 0, 0);
    force dut.u_mis_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_mis_cnt.cnt_q;
    m_mis = 32'hFFFF_FFFF;
    drive(1, 1, 1, 32'h1c00_0c00, 32'h1c00_0d00, 0, 0);
    cycle("wrap");
    check("wrap:mis_lit", 64'(mis_cnt), 64'd0);

    // Async reset while the redirect from the wrap step is pending.
    drive(0, 0, 0, '0, '0, 0, 0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(1, 0) == 1, $urandom_range(9, 0) < 3, $urandom_range(1, 0) == 1,
            W'($urandom), W'($urandom), $urandom_range(19, 0) == 0,
            $urandom_range(9, 0) < 4);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
